// File: rtl/dmem_pkg.sv
// Shared types and port encodings for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin: on a tie the requester that did not own last wins.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = PORT_CPU;
    case (req_i)
      2'b01:   winner_o = PORT_CPU;
      2'b10:   winner_o = PORT_HOST;
      2'b11:   winner_o = ~last_i;
      default: winner_o = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU load/store path and a host loader,
// with round-robin arbitration and fixed-latency access sequencing.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LastCnt = CW'(MEM_LAT);

  if (MEM_LAT == 0 || MEM_LAT > 15) begin : g_bad_lat
    $error("dmem_arbiter: MEM_LAT must be in 1..15");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          gnt_valid, gnt_winner;
  logic          done;

  rr_arb2 u_arb (
    .req_i    ({host_req, cpu_req}),
    .last_i   (owner_q),
    .valid_o  (gnt_valid),
    .winner_o (gnt_winner)
  );

  assign done = (state_q == ACCESS) && (cnt_q == LastCnt);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ACCESS;
          cnt_d   = '0;
          owner_d = gnt_winner;
          we_d    = (gnt_winner == PORT_HOST) ? host_we    : cpu_we;
          addr_d  = (gnt_winner == PORT_HOST) ? host_addr  : cpu_addr;
          wdata_d = (gnt_winner == PORT_HOST) ? host_wdata : cpu_wdata;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!we_q) begin
            if (owner_q == PORT_HOST) host_rdata_d = mem_rdata;
            else                      cpu_rdata_d  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= PORT_HOST;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign mem_en    = (state_q == ACCESS) && (cnt_q == '0);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == ACCESS);
  assign owner     = owner_q;
  assign cpu_ack   = done && (owner_q == PORT_CPU);
  assign host_ack  = done && (owner_q == PORT_HOST);
  assign cpu_stall = cpu_req & ~cpu_ack;

  // Load data is forwarded in the ack cycle so it is valid alongside the ack pulse.
  assign cpu_rdata  = (cpu_ack  && !we_q) ? mem_rdata : cpu_rdata_q;
  assign host_rdata = (host_ack && !we_q) ? mem_rdata : host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a fixed-latency memory model.
module tb_dmem_arbiter;

  localparam int unsigned AW      = 8;
  localparam int unsigned DW      = 8;
  localparam int unsigned MEM_LAT = 2;
  localparam int          ACK_LAT = MEM_LAT + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, host_req, host_we;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [DW-1:0] cpu_wdata, host_wdata;
  logic [DW-1:0] cpu_rdata, host_rdata;
  logic          cpu_ack, cpu_stall, host_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, owner;

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears exactly MEM_LAT cycles after mem_en, garbage otherwise.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [MEM_LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= mem_en ? mem[mem_addr] : 8'hEE;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            en_total = 0, cpu_ack_total = 0, host_ack_total = 0, ack_wide = 0;
  int            last_en_cyc = 0;
  logic          last_we = 1'b0, prev_cpu_ack = 1'b0, prev_host_ack = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  always @(negedge clk) begin
    if (mem_en) begin
      en_total    <= en_total + 1;
      last_we     <= mem_we;
      last_addr   <= mem_addr;
      last_wdata  <= mem_wdata;
      last_en_cyc <= cyc;
    end
    if (cpu_ack)  cpu_ack_total  <= cpu_ack_total + 1;
    if (host_ack) host_ack_total <= host_ack_total + 1;
    if ((cpu_ack && prev_cpu_ack) || (host_ack && prev_host_ack)) ack_wide <= ack_wide + 1;
    prev_cpu_ack  <= cpu_ack;
    prev_host_ack <= host_ack;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic port, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata);
    if (port) begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic wait_ack(input logic port, output int lat, output logic [7:0] rd);
    logic ok = 1'b0;
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (port ? host_ack : cpu_ack) begin
        lat = i;
        rd  = port ? host_rdata : cpu_rdata;
        ok  = 1'b1;
        break;
      end
    end
    check("ack seen within bound", {31'd0, ok}, 32'd1);
  endtask

  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [7:0] exp_cpu_rd = '0, exp_host_rd = '0, rd;
    int         lat, en0, ack0, hack0, n, host_ack_cyc;
    logic [1:0] order [4];
    int         ack_cyc [4];

    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
    vecs[3] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h5A, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 1'b1, 8'h00, 8'hC3, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hC3};
    vecs[8] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};

    // Reset held with both requesters active.
    reset = 1'b0;
    cpu_req = 1'b1;  cpu_we = 1'b1;  cpu_addr = 8'h11;  cpu_wdata = 8'h22;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h33; host_wdata = 8'h44;
    repeat (3) @(negedge clk);
    check("reset cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check("reset host_ack", {31'd0, host_ack}, 32'd0);
    check("reset mem_en", {31'd0, mem_en}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset owner", {31'd0, owner}, 32'd1);
    check("reset mem_addr", {24'd0, mem_addr}, 32'd0);
    check("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("reset cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("reset host_rdata", {24'd0, host_rdata}, 32'd0);
    check("reset mem_en count", en_total, 32'd0);
    cpu_req = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      en0 = en_total;
      start_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      wait_ack(vecs[i].port, lat, rd);
      if (vecs[i].port) host_req = 1'b0; else cpu_req = 1'b0;
      check($sformatf("v%0d ack latency", i), lat, ACK_LAT);
      check($sformatf("v%0d mem_en pulses", i), en_total - en0, 32'd1);
      check($sformatf("v%0d mem_we", i), {31'd0, last_we}, {31'd0, vecs[i].we});
      check($sformatf("v%0d mem_addr", i), {24'd0, last_addr}, {24'd0, vecs[i].addr});
      if (vecs[i].we)
        check($sformatf("v%0d mem_wdata", i), {24'd0, last_wdata}, {24'd0, vecs[i].wdata});
      else begin
        check($sformatf("v%0d rdata with ack", i), {24'd0, rd}, {24'd0, vecs[i].exp_rdata});
        if (vecs[i].port) exp_host_rd = vecs[i].exp_rdata;
        else              exp_cpu_rd  = vecs[i].exp_rdata;
      end
      @(negedge clk);
      check($sformatf("v%0d owner", i), {31'd0, owner}, {31'd0, vecs[i].port});
      check($sformatf("v%0d busy after ack", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d cpu_rdata held", i), {24'd0, cpu_rdata}, {24'd0, exp_cpu_rd});
      check($sformatf("v%0d host_rdata held", i), {24'd0, host_rdata}, {24'd0, exp_host_rd});
    end

    // Host drops req during ACCESS: transaction still completes and acks.
    start_req(1'b1, 1'b1, 8'h30, 8'h55);
    @(negedge clk);
    host_req = 1'b0;
    wait_ack(1'b1, lat, rd);
    check("dropped req ack latency", lat, ACK_LAT - 1);
    @(negedge clk);
    start_req(1'b1, 1'b0, 8'h30, 8'h00);
    wait_ack(1'b1, lat, rd);
    host_req = 1'b0;
    check("dropped req write landed", {24'd0, rd}, 32'h55);
    @(negedge clk);

    // Contention: both held for four transactions, owner was host so CPU goes first.
    start_req(1'b0, 1'b0, 8'h10, 8'h00);
    start_req(1'b1, 1'b0, 8'h20, 8'h00);
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (cpu_ack || host_ack) begin
        check("contention single ack", {30'd0, cpu_ack, host_ack} & 32'h3, cpu_ack ? 32'h2 : 32'h1);
        order[n]   = host_ack ? 2'd1 : 2'd0;
        ack_cyc[n] = cyc;
        check("contention rdata", {24'd0, host_ack ? host_rdata : cpu_rdata},
              host_ack ? 32'h3C : 32'hA5);
        n++;
        if (n == 4) begin
          cpu_req  = 1'b0;
          host_req = 1'b0;
        end
      end
    end
    check("contention ack count", n, 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("contention grant %0d", k), {30'd0, order[k]}, k % 2);
    for (int k = 1; k < 4; k++)
      check($sformatf("contention spacing %0d", k), ack_cyc[k] - ack_cyc[k-1], MEM_LAT + 2);
    @(negedge clk);

    // CPU request arrives while host is in ACCESS: stall until its own ack.
    en0 = en_total;
    host_ack_cyc = 0;
    start_req(1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    check("stall host busy", {31'd0, busy}, 32'd1);
    check("stall host owner", {31'd0, owner}, 32'd1);
    start_req(1'b0, 1'b0, 8'h10, 8'h00);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (host_ack) begin
        host_ack_cyc = cyc;
        check("stall host_rdata", {24'd0, host_rdata}, 32'h3C);
        host_req = 1'b0;
      end
      if (cpu_ack) begin
        check("stall low at ack", {31'd0, cpu_stall}, 32'd0);
        check("stall cpu_rdata", {24'd0, cpu_rdata}, 32'hA5);
        cpu_req = 1'b0;
        n = 1;
        break;
      end
      check("stall high while waiting", {31'd0, cpu_stall}, 32'd1);
    end
    check("stall cpu acked", n, 32'd1);
    check("stall mem_en pulses", en_total - en0, 32'd2);
    check("stall cpu mem_en after host ack", {31'd0, (last_en_cyc > host_ack_cyc)}, 32'd1);
    @(negedge clk);

    // Abort: reset asserted in the mem_en cycle of a CPU store.
    start_req(1'b0, 1'b1, 8'h40, 8'h77);
    @(negedge clk);
    check("abort in ACCESS", {31'd0, mem_en & busy}, 32'd1);
    ack0  = cpu_ack_total;
    hack0 = host_ack_total;
    reset = 1'b0;
    #1;
    check("abort mem_en", {31'd0, mem_en}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check("abort owner", {31'd0, owner}, 32'd1);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("abort no cpu_ack", cpu_ack_total - ack0, 32'd0);
    check("abort no host_ack", host_ack_total - hack0, 32'd0);
    check("ack pulses one cycle wide", ack_wide, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
